fifo_wr_arbiter: RTL

//  Round-robin packet arbiter that shares the enqueue port of one RAM-based FIFO among N_REQ requesters.
//  A grant is held for a whole packet, so beats of different requesters never interleave in the FIFO.
//  It writes only when the FIFO is not full and enforces a per-packet beat limit (watchdog).
//  It sits between N producer blocks and the FIFO write side (i_wren / i_wrdata / o_full).

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N producers, the arbiter and one FIFO enqueue port.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ-1:0]        i_last;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        o_ack;
  logic [N_REQ-1:0]        o_gnt;
  logic                    o_err;
  logic                    o_fifo_wren;
  logic [DATA_W-1:0]       o_fifo_wrdata;
  logic                    i_fifo_full;

  // arbiter side
  modport slave (
    input  i_req, i_last, i_data, i_fifo_full,
    output o_ack, o_gnt, o_err, o_fifo_wren, o_fifo_wrdata
  );

  // producers + FIFO side
  modport master (
    output i_req, i_last, i_data, i_fifo_full,
    input  o_ack, o_gnt, o_err, o_fifo_wren, o_fifo_wrdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for a FIFO enqueue port. Ownership is held for
// a whole packet; a beat watchdog forces release after MAX_BEATS accepts.

// Per-requester slice: accept gating and data masking for the owner mux.
module fifo_wr_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              gnt,
  input  logic              req,
  input  logic              full,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  output logic [DATA_W-1:0] data_m
);
  assign ack    = gnt & req & ~full;
  assign data_m = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                       state, state_nxt;
  logic [N_REQ-1:0]             gnt, gnt_nxt;
  logic [PTR_W-1:0]             own, own_nxt;
  logic [PTR_W-1:0]             rr_ptr, rr_nxt;
  logic [CNT_W-1:0]             beat_cnt, cnt_nxt;
  logic                         err_q, err_nxt;

  logic [N_REQ-1:0]             ack;
  logic [N_REQ-1:0][DATA_W-1:0] data_m;
  logic [DATA_W-1:0]            wrdata;
  logic                         accept, last_own, at_limit;
  logic                         win_found;
  logic [PTR_W-1:0]             win_idx;
  logic [PTR_W:0]               cand;

  // gnt is only non-zero in BUSY, so a lane ack already implies BUSY
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .gnt    (gnt[g]),
      .req    (bus.i_req[g]),
      .full   (bus.i_fifo_full),
      .data   (bus.i_data[g*DATA_W +: DATA_W]),
      .ack    (ack[g]),
      .data_m (data_m[g])
    );
  end

  // one-hot grant makes the OR of masked lanes equal the owner's data
  always_comb begin
    wrdata = '0;
    for (int g = 0; g < N_REQ; g++) wrdata = wrdata | data_m[g];
  end

  assign accept   = |ack;
  assign last_own = |(gnt & bus.i_last);
  assign at_limit = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  // round-robin winner: scan downwards so the first hit from rr_ptr wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
      if (bus.i_req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // next-state: arbitrate in IDLE, count beats and detect packet end in BUSY
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    own_nxt   = own;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt   = N_REQ'(1) << win_idx;
          own_nxt   = win_idx;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (last_own || at_limit) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            rr_nxt    = (own == PTR_W'(N_REQ - 1)) ? '0 : own + PTR_W'(1);
            err_nxt   = ~last_own;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register; reset drops any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      own      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      own      <= own_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.o_ack         = ack;
  assign bus.o_gnt         = gnt;
  assign bus.o_err         = err_q;
  assign bus.o_fifo_wren   = accept;
  assign bus.o_fifo_wrdata = wrdata;
endmodule
